// File: rtl/stage1_pkg.sv
// stage1_pkg: shared types and constants for the first cipher stage.
//   stage1_mode_t      - 2-bit stage key {k9,k8}, named by its encrypt-side effect
//   stage1_inv_state_t - sequencer states of the inverse stage
//   inv_byte()         - per-byte decrypt operation for a given mode
package stage1_pkg;

  localparam int NROWS = 4;
  localparam int BW    = 8;

  typedef enum logic [1:0] {
    MODE_INV  = 2'b00,
    MODE_ROR2 = 2'b01,
    MODE_ROL2 = 2'b10,
    MODE_HINV = 2'b11
  } stage1_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stage1_inv_state_t;

  // Undo the encrypt-side byte op: each mode applies its own inverse.
  function automatic logic [BW-1:0] inv_byte(input stage1_mode_t mode,
                                             input logic [BW-1:0] b);
    logic [BW-1:0] r;
    case (mode)
      MODE_INV:  r = ~b;
      MODE_ROR2: r = {b[BW-3:0], b[BW-1:BW-2]};      // rotate left by 2
      MODE_ROL2: r = {b[1:0], b[BW-1:2]};            // rotate right by 2
      MODE_HINV: r = {b[BW-1:BW/2], ~b[BW/2-1:0]};
      default:   r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stage1_inv_row.sv
// stage1_inv_row: combinational inverse of one 4-byte row.
//   row_i - row as stored in the block register
//   mode  - latched stage key {k9,k8}
//   row_o - recovered row; every byte gets the same inverse op
module stage1_inv_row
  import stage1_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [NB*BW-1:0] row_i,
  input  logic [1:0]       mode,
  output logic [NB*BW-1:0] row_o
);

  for (genvar g = 0; g < NB; g++) begin : g_byte
    assign row_o[g*BW +: BW] = inv_byte(stage1_mode_t'(mode), row_i[g*BW +: BW]);
  end

endmodule

// File: rtl/stage1_inv_seq.sv
// stage1_inv_seq: sequential inverse of the first cipher stage.
// Accepts a 16-byte block plus its stage key, then undoes the byte transform
// one 4-byte row per enabled clock (row 0 = MSB word), and presents the
// recovered block on a valid/ready output.
//   clk, rst             - clock, async active-high reset
//   enable               - run/freeze for IDLE and RUN; DONE handshake ignores it
//   in_valid/in_ready    - input handshake; in_data (a0..d3 from MSB), in_key
//   out_valid/out_ready  - output handshake; out_data same byte order
module stage1_inv_seq #(
  parameter int NROWS = 4,
  parameter int BW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NROWS*4*BW-1:0] in_data,
  input  logic [1:0]            in_key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NROWS*4*BW-1:0] out_data
);

  import stage1_pkg::*;

  localparam int RW    = 4 * BW;      // bits per row
  localparam int BLK_W = NROWS * RW;

  stage1_inv_state_t state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        key_q, key_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [RW-1:0]     row_cur, row_inv;
  logic              accept, step;

  assign accept = in_valid & in_ready;
  assign step   = (state_q == RUN) & enable;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      key_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (step && row_q == 2'(NROWS-1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;   // not gated by enable
      default: state_d = IDLE;
    endcase
  end

  // Pick the row currently being worked on (row 0 sits in the top word).
  always_comb begin
    row_cur = '0;
    for (int r = 0; r < NROWS; r++)
      if (row_q == 2'(r)) row_cur = blk_q[(NROWS-1-r)*RW +: RW];
  end

  stage1_inv_row #(.NB(4)) u_row (
    .row_i (row_cur),
    .mode  (key_q),
    .row_o (row_inv)
  );

  // Datapath: latch on accept, rewrite one row in place per enabled RUN cycle.
  always_comb begin
    blk_d = blk_q;
    row_d = row_q;
    key_d = key_q;
    if (accept) begin
      blk_d = in_data;
      key_d = in_key;
      row_d = '0;
    end else if (step) begin
      for (int r = 0; r < NROWS; r++)
        if (row_q == 2'(r)) blk_d[(NROWS-1-r)*RW +: RW] = row_inv;
      row_d = row_q + 2'd1;    // wraps 3 -> 0 as the block enters DONE
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == IDLE) & enable & ~rst;
    out_valid = (state_q == DONE);
    out_data  = blk_q;
  end

endmodule

// File: tb/tb_stage1_inv_seq.sv
// tb_stage1_inv_seq: directed + randomized bench for stage1_inv_seq.
// Expected blocks come from an arithmetic byte model of the encrypt and
// decrypt directions of the stage.
module tb_stage1_inv_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   in_key = '0;
  logic         in_ready, out_valid;
  logic [127:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage1_inv_seq #(.NROWS(4), .BW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---- reference model ----
  function automatic logic [7:0] enc_byte(input logic [1:0] k, input logic [7:0] b);
    case (k)
      2'd0:    return 8'hFF ^ b;
      2'd1:    return (b >> 2) | (b << 6);
      2'd2:    return (b << 2) | (b >> 6);
      default: return b ^ 8'h0F;
    endcase
  endfunction

  function automatic logic [7:0] dec_byte(input logic [1:0] k, input logic [7:0] b);
    case (k)
      2'd0:    return 8'hFF ^ b;
      2'd1:    return (b << 2) | (b >> 6);
      2'd2:    return (b >> 2) | (b << 6);
      default: return b ^ 8'h0F;
    endcase
  endfunction

  function automatic logic [127:0] enc_blk(input logic [127:0] d, input logic [1:0] k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = enc_byte(k, d[i*8 +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] dec_blk(input logic [127:0] d, input logic [1:0] k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = dec_byte(k, d[i*8 +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---- helpers ----
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called away from the posedge; returns at the negedge after the accept edge.
  task automatic accept_blk(input logic [127:0] d, input logic [1:0] k);
    int n = 0;
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_idle", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    in_data  = rnd128();          // later input changes must not matter
    in_key   = 2'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_fall"}, 128'(out_valid), 128'd0);
    chk({tag, "_ir_rise"}, 128'(in_ready), 128'(enable));
  endtask

  task automatic run_blk(input string tag, input logic [127:0] d, input logic [1:0] k,
                         input logic [127:0] exp);
    int lat;
    accept_blk(d, k);
    wait_valid(lat);
    chk({tag, "_lat"}, 128'(lat), 128'd4);
    chk({tag, "_data"}, out_data, exp);
    drain(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] orig, d;
    logic [1:0] k;

    // reset state
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 128'(in_ready), 128'd1);

    // directed keys
    run_blk("k00_ff", {16{8'hFF}}, 2'd0, 128'h0);
    run_blk("k01_81", {16{8'h81}}, 2'd1, {16{8'h06}});
    run_blk("k10_81", {16{8'h81}}, 2'd2, {16{8'h60}});

    // key 11, in_key forced to 00 during RUN
    accept_blk({16{8'hA5}}, 2'd3);
    in_key = 2'd0;
    wait_valid(lat);
    chk("k11_lat", 128'(lat), 128'd4);
    chk("k11_data", out_data, {16{8'hAA}});
    drain("k11");

    // round trip for each key
    for (int kk = 0; kk < 4; kk++) begin
      for (int j = 0; j < 3; j++) begin
        orig = rnd128();
        run_blk("roundtrip", enc_blk(orig, 2'(kk)), 2'(kk), orig);
      end
    end

    // random blocks, distinct per-byte values
    for (int j = 0; j < 4; j++) begin
      d = rnd128();
      k = 2'($urandom);
      run_blk("rand_dec", d, k, dec_blk(d, k));
    end

    // backpressure: out_ready low for 3 cycles in DONE
    d = rnd128();
    k = 2'($urandom);
    accept_blk(d, k);
    wait_valid(lat);
    chk("bp_lat", 128'(lat), 128'd4);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", out_data, dec_blk(d, k));
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    // handshake completes with enable low
    enable = 1'b0;
    drain("bp_en_low");
    enable = 1'b1;
    #1;
    chk("bp_ir_reenable", 128'(in_ready), 128'd1);

    // enable low for 2 cycles mid-RUN delays out_valid by exactly 2
    d = rnd128();
    k = 2'($urandom);
    accept_blk(d, k);
    tick();                // row 0 done
    enable = 1'b0;
    tick();
    tick();
    chk("stall_no_valid", 128'(out_valid), 128'd0);
    chk("stall_in_ready", 128'(in_ready), 128'd0);
    enable = 1'b1;
    wait_valid(lat);
    chk("stall_lat", 128'(lat + 3), 128'd6);
    chk("stall_data", out_data, dec_blk(d, k));
    drain("stall");

    // reset after E2 discards the block
    d = rnd128();
    accept_blk(d, 2'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_out_data", out_data, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ir_after", 128'(in_ready), 128'd1);
    tick();
    chk("midrst_no_valid", 128'(out_valid), 128'd0);
    d = rnd128();
    run_blk("post_rst", d, 2'd2, dec_blk(d, 2'd2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
